uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx serializer between N requesters.
- Accepts one byte per handshake from the winning requester and drives the serializer's start/data/enable pins.
- Waits for the frame-complete pulse, then re-arbitrates.
- Sits between client logic (command engines, debug streams) and the single TX pin's serializer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATAWIDTH, 8, frame payload width; must match the serializer.
- TIMEOUT_CYC, 65535, clk cycles allowed in WAIT_DONE before abort.
- GRANT_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  clock
- tx_rst  in  1  reset, asynchronous, active-high
- ctrl_en  in  1  allow new grants
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATAWIDTH  packed payloads; requester i occupies [i*DATAWIDTH +: DATAWIDTH]
- req_ready  out  NUM_REQ  one-hot accept
- utx_en  out  1  to serializer tx_en
- utx_start  out  1  to serializer tx_start
- utx_din  out  DATAWIDTH  to serializer din
- utx_done  in  1  serializer tx_done, 1-cycle pulse
- utx_busy  in  1  serializer tx_busy
- grant_id  out  GRANT_W  index of current/last owner
- arb_busy  out  1  state != IDLE
- err_timeout  out  1  1-cycle pulse on abort

Behaviour:
- Reset values:
  - state IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - utx_start 0, utx_din 0, utx_en 0, grant_id 0, err_timeout 0.
  - req_ready 0; timeout counter 0.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Winner = first set req_valid bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally only when ctrl_en=1, utx_busy=0 and any req_valid is set. All other ready bits are 0.
  - On valid&ready:
    - latch req_data slice into utx_din;
    - grant_id <= winner; rr_ptr <= winner;
    - go to LAUNCH.
  - req_ready must never be high in any other state.
- LAUNCH:
  - utx_start = 1 for exactly this one cycle (registered).
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for utx_busy=1, then go to WAIT_DONE.
  - utx_done seen here counts as completion; go to IDLE.
- WAIT_DONE:
  - On utx_done go to IDLE; the next grant is possible in the following cycle.
  - Timeout counter clears on LAUNCH and increments every cycle in WAIT_BUSY/WAIT_DONE.
  - At TIMEOUT_CYC-1 without done: pulse err_timeout and return to IDLE. The frame is dropped and rr_ptr keeps its advance.
- utx_en:
  - = ctrl_en OR (state != IDLE).
  - Deasserting ctrl_en mid-frame lets the frame complete; no new grant follows.
- utx_din:
  - holds its value until the next acceptance.
- Simultaneous events:
  - utx_done and a new req_valid in the same cycle: done is processed first; the grant comes in the next IDLE cycle.
  - req_valid dropping before ready: no transfer; re-arbitrate each cycle.
- Reset mid-operation:
  - all state clears immediately and utx_start drops.
  - The serializer shares tx_rst, so no partial-frame recovery is needed.
- Fairness:
  - with all requesters valid, grants rotate 0,1,2,...,NUM_REQ-1,0.

Optional Feature:
- Macro: UART_TX_ARB_LOCK_EN.
- With the macro:
  - adds input req_lock[NUM_REQ-1:0] and internal lock_active.
  - If req_lock[winner]=1 at acceptance, lock_active is set.
  - While lock_active is set, IDLE grants only grant_id; other requesters see ready=0 even if grant_id is not valid.
  - Acceptance with req_lock=0 clears lock_active.
  - err_timeout also clears lock_active.
- Without the macro: no req_lock port and pure round-robin.

Decomposition:
- Package uart_tx_arb_pkg:
  - state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - default DATAWIDTH/NUM_REQ constants;
  - grant-index width function.
- One natural sub-module, rr_pick: combinational round-robin priority encoder (req vector, pointer → one-hot + index, any).

Test Plan:
- Single requester: req1 valid, data 0xA5 → ready[1] one cycle, utx_start one cycle later with utx_din=0xA5, grant_id=1; next grant only after utx_done.
- All 4 valid continuously, data 0x10..0x13 → utx_din sequence 0x10,0x11,0x12,0x13,0x10; exactly one ready bit per frame.
- ctrl_en dropped during WAIT_DONE → current frame completes (utx_en held 1), no further req_ready until ctrl_en=1.
- Serializer held dead (utx_busy/utx_done stuck 0), TIMEOUT_CYC=16 → err_timeout pulses 16 cycles after LAUNCH, state IDLE, next requester served.
- tx_rst asserted in WAIT_DONE → utx_start, req_ready, arb_busy=0 immediately; first grant after release goes to requester 0.
- UART_TX_ARB_LOCK_EN: req2 sends 3 bytes, lock=1,1,0, with req0/req3 valid → grants 2,2,2, then 3, then 0.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb_pkg
// Description : Shared types and constants for the UART TX arbiter slice:
//               sequencer state encoding, default sizes and the grant-index
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

    localparam int c_DEF_NUM_REQ   = 4;
    localparam int c_DEF_DATAWIDTH = 8;

    // Sequencer states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Width of an index into n requesters (never narrower than one bit)
    function automatic int grant_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority encoder. The search starts
//               at i_ptr+1 and wraps modulo NUM_REQ; returns the first set
//               request as one-hot and index, plus an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int GRANT_W = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [GRANT_W-1:0] o_grant_idx,
    output logic               o_any
);

    int w_best;
    int w_dist;

    // Pick the set request with the smallest rotational distance past i_ptr
    always_comb begin
        w_best      = NUM_REQ;
        w_dist      = 0;
        o_grant_idx = '0;
        o_any       = |i_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            // distance 0 is the slot right after the pointer
            w_dist = (i + NUM_REQ - 1 - int'(i_ptr)) % NUM_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_grant_idx = GRANT_W'(i);
            end
        end
        o_grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant_oh[i] = o_any && (o_grant_idx == GRANT_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter/sequencer sharing one uart_tx serializer
//               between NUM_REQ requesters. Accepts one byte per handshake,
//               launches it, waits for frame completion (with timeout) and
//               re-arbitrates. Optional macro UART_TX_ARB_LOCK_EN adds
//               req_lock, letting a winner keep the serializer for a burst.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = c_DEF_NUM_REQ,
    parameter int DATAWIDTH   = c_DEF_DATAWIDTH,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GRANT_W     = grant_width(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         tx_rst,
    input  logic                         ctrl_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           req_lock,
`endif
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         utx_en,
    output logic                         utx_start,
    output logic [DATAWIDTH-1:0]         utx_din,
    input  logic                         utx_done,
    input  logic                         utx_busy,
    output logic [GRANT_W-1:0]           grant_id,
    output logic                         arb_busy,
    output logic                         err_timeout
);

    localparam int                  c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GRANT_W-1:0]  c_PTR_RST  = GRANT_W'(NUM_REQ - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [GRANT_W-1:0]     r_rr_ptr;
    logic [GRANT_W-1:0]     r_grant_id;
    logic [DATAWIDTH-1:0]   r_din;
    logic                   r_start;
    logic [c_TMO_W-1:0]     r_tmo_cnt;

    logic [NUM_REQ-1:0]     w_cand;
    logic [NUM_REQ-1:0]     w_win_oh;
    logic [GRANT_W-1:0]     w_win_idx;
    logic                   w_win_any;
    logic [DATAWIDTH-1:0]   w_win_data;
    logic                   w_accept;
    logic                   w_in_wait;
    logic                   w_tmo_hit;

`ifdef UART_TX_ARB_LOCK_EN
    logic                   r_lock_active;

    // While locked, only the previous owner is a candidate
    always_comb begin
        w_cand = req_valid;
        if (r_lock_active) begin
            w_cand = req_valid & (NUM_REQ'(1) << r_grant_id);
        end
    end

    // Lock follows the winner's req_lock at acceptance; a timeout releases it
    always_ff @(posedge clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_lock_active <= 1'b0;
        end else if (w_accept) begin
            r_lock_active <= |(req_lock & w_win_oh);
        end else if (w_tmo_hit) begin
            r_lock_active <= 1'b0;
        end
    end
`else
    assign w_cand = req_valid;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .i_req       (w_cand),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_win_oh),
        .o_grant_idx (w_win_idx),
        .o_any       (w_win_any)
    );

    // Select the winning requester's payload slice
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_data = req_data[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    assign w_accept    = (r_state == IDLE) && ctrl_en && !utx_busy && w_win_any;
    assign w_in_wait   = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    // A done pulse on the final cycle still counts as completion, not abort
    assign w_tmo_hit   = w_in_wait && !utx_done && (r_tmo_cnt == c_TMO_LAST);

    assign req_ready   = w_accept ? w_win_oh : '0;
    assign utx_en      = ctrl_en || (r_state != IDLE);
    assign utx_start   = r_start;
    assign utx_din     = r_din;
    assign grant_id    = r_grant_id;
    assign arb_busy    = (r_state != IDLE);
    assign err_timeout = w_tmo_hit;

    // Next-state logic of the launch/complete sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = LAUNCH;
            end
            LAUNCH: begin
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (utx_done || w_tmo_hit) w_state_next = IDLE;
                else if (utx_busy)         w_state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (utx_done || w_tmo_hit) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, handshake capture, start strobe and timeout counter registers
    always_ff @(posedge clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= c_PTR_RST;
            r_grant_id <= '0;
            r_din      <= '0;
            r_start    <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_accept;
            if (w_accept) begin
                r_din      <= w_win_data;
                r_grant_id <= w_win_idx;
                r_rr_ptr   <= w_win_idx;
            end
            if (r_state == LAUNCH) begin
                r_tmo_cnt <= '0;
            end else if (w_in_wait) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with directed and
//               randomized frames against a behavioural round-robin model.
//               Define UART_TX_ARB_LOCK_EN to also exercise req_lock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          tx_rst;
    logic          ctrl_en;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          utx_en;
    logic          utx_start;
    logic [DW-1:0] utx_din;
    logic          utx_done;
    logic          utx_busy;
    logic [1:0]    grant_id;
    logic          arb_busy;
    logic          err_timeout;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N-1:0]  req_lock;
`endif

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .DATAWIDTH   (DW),
        .TIMEOUT_CYC (TMO),
        .GRANT_W     (2)
    ) dut (
        .clk         (clk),
        .tx_rst      (tx_rst),
        .ctrl_en     (ctrl_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .utx_en      (utx_en),
        .utx_start   (utx_start),
        .utx_din     (utx_din),
        .utx_done    (utx_done),
        .utx_busy    (utx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: last owner pointer and burst lock
    int m_ptr     = N - 1;
    bit m_lock    = 1'b0;
    int m_lock_id = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next owner from the round-robin rule; -1 when nobody can be granted
    function automatic int model_pick(input logic [N-1:0] v);
        if (m_lock) return v[m_lock_id] ? m_lock_id : -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // From IDLE with inputs applied: handshake, LAUNCH, then into WAIT_BUSY
    task automatic start_frame(output int w);
        logic [DW-1:0] d;
        #1;
        w = model_pick(req_valid);
        if (w < 0) begin
            check("no_winner_ready", {28'd0, req_ready}, 32'd0);
            return;
        end
        d = req_data[w*DW +: DW];
        check("ready_onehot", {28'd0, req_ready}, 32'd1 << w);
        tick();
        check("launch_start", {31'd0, utx_start}, 32'd1);
        check("launch_din", {24'd0, utx_din}, {24'd0, d});
        check("launch_grant", {30'd0, grant_id}, w);
        check("launch_ready", {28'd0, req_ready}, 32'd0);
        check("launch_utx_en", {31'd0, utx_en}, 32'd1);
        m_ptr = w;
`ifdef UART_TX_ARB_LOCK_EN
        m_lock    = req_lock[w];
        m_lock_id = w;
`endif
        tick();
        check("start_one_cycle", {31'd0, utx_start}, 32'd0);
    endtask

    // From WAIT_BUSY: optional busy phase of 'hold' extra cycles, then done
    task automatic finish_frame(input bit via_busy, input int hold);
        if (via_busy) begin
            utx_busy = 1'b1;
            tick();
            repeat (hold) begin
                check("ready_in_wait", {28'd0, req_ready}, 32'd0);
                tick();
            end
        end
        utx_busy = 1'b0;
        utx_done = 1'b1;
        #1;
        check("no_timeout", {31'd0, err_timeout}, 32'd0);
        check("busy_at_done", {31'd0, arb_busy}, 32'd1);
        tick();
        utx_done = 1'b0;
        #1;
        check("idle_after_done", {31'd0, arb_busy}, 32'd0);
    endtask

    task automatic frame(input bit via_busy, input int hold);
        int w;
        start_frame(w);
        if (w >= 0) finish_frame(via_busy, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] exp_ids [5];

        // ---------------- reset state ----------------
        tx_rst    = 1'b1;
        ctrl_en   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        utx_done  = 1'b0;
        utx_busy  = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", {31'd0, utx_start}, 32'd0);
        check("rst_din", {24'd0, utx_din}, 32'd0);
        check("rst_utx_en", {31'd0, utx_en}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_err", {31'd0, err_timeout}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, arb_busy}, 32'd0);
        @(negedge clk);
        tx_rst = 1'b0;
        m_ptr  = N - 1;

        // ---------------- fairness: all valid ----------------
        ctrl_en   = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            frame(1'b1, 2);
            check("fair_din", {24'd0, utx_din}, 32'h10 + (i % 4));
            check("fair_grant", {30'd0, grant_id}, i % 4);
        end

        // ---------------- single requester ----------------
        req_valid = 4'b0010;
        req_data  = {8'h77, 8'h66, 8'hA5, 8'h55};
        frame(1'b1, 3);
        check("single_din", {24'd0, utx_din}, 32'hA5);
        check("single_grant", {30'd0, grant_id}, 32'd1);

`ifdef UART_TX_ARB_LOCK_EN
        // ---------------- burst lock ----------------
        exp_ids   = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd0};
        req_valid = 4'b1101;
        req_data  = 32'hD3C2_B1A0;
        for (int i = 0; i < 5; i++) begin
            req_lock = (i < 2) ? 4'b0100 : 4'b0000;
            if (i == 1) begin
                req_valid = 4'b1001;
                #1;
                check("lock_holds_others", {28'd0, req_ready}, 32'd0);
                tick();
                req_valid = 4'b1101;
            end
            frame(1'b1, 1);
            check("lock_grant", {28'd0, 2'd0, grant_id}, {28'd0, exp_ids[i]});
        end
        req_lock = '0;
`endif

        // ---------------- randomized frames ----------------
        for (int i = 0; i < 25; i++) begin
            req_valid = 4'($urandom_range(1, 15));
            req_data  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ctrl_en = 1'b0;
                #1;
                check("rand_ctrl_off_ready", {28'd0, req_ready}, 32'd0);
                check("rand_ctrl_off_en", {31'd0, utx_en}, 32'd0);
                tick();
                ctrl_en = 1'b1;
            end
            frame(1'($urandom_range(0, 1)), $urandom_range(0, 5));
        end

        // ---------------- ctrl_en dropped mid-frame ----------------
        req_valid = 4'hF;
        req_data  = $urandom;
        start_frame(w);
        utx_busy = 1'b1;
        tick();
        ctrl_en = 1'b0;
        #1;
        check("ctrl_drop_utx_en", {31'd0, utx_en}, 32'd1);
        tick();
        check("ctrl_drop_still_busy", {31'd0, arb_busy}, 32'd1);
        finish_frame(1'b0, 0);
        repeat (3) begin
            check("ctrl_off_no_ready", {28'd0, req_ready}, 32'd0);
            check("ctrl_off_utx_en", {31'd0, utx_en}, 32'd0);
            tick();
        end
        ctrl_en = 1'b1;
        frame(1'b1, 0);

        // ---------------- dead serializer -> timeout ----------------
        req_valid = 4'hF;
        req_data  = $urandom;
        start_frame(w);
        for (int k = 1; k < TMO; k++) begin
            check("tmo_early", {31'd0, err_timeout}, 32'd0);
            tick();
        end
        check("tmo_pulse", {31'd0, err_timeout}, 32'd1);
        tick();
        check("tmo_pulse_width", {31'd0, err_timeout}, 32'd0);
        check("tmo_idle", {31'd0, arb_busy}, 32'd0);
        check("tmo_next_ready", {28'd0, req_ready}, 32'd1 << ((w + 1) % N));
        frame(1'b1, 1);

        // ---------------- reset in WAIT_DONE ----------------
        start_frame(w);
        utx_busy = 1'b1;
        tick();
        #1;
        tx_rst = 1'b1;
        #1;
        check("rstw_busy", {31'd0, arb_busy}, 32'd0);
        check("rstw_ready", {28'd0, req_ready}, 32'd0);
        check("rstw_start", {31'd0, utx_start}, 32'd0);
        check("rstw_grant", {30'd0, grant_id}, 32'd0);
        utx_busy = 1'b0;
        @(negedge clk);
        tx_rst = 1'b0;
        m_ptr  = N - 1;
        m_lock = 1'b0;

        // ---------------- reset in LAUNCH ----------------
        #1;
        check("rstl_ready", {28'd0, req_ready}, 32'd1);
        tick();
        check("rstl_start_hi", {31'd0, utx_start}, 32'd1);
        tx_rst = 1'b1;
        #1;
        check("rstl_start_drop", {31'd0, utx_start}, 32'd0);
        @(negedge clk);
        tx_rst = 1'b0;
        m_ptr  = N - 1;
        frame(1'b1, 1);
        check("post_rst_grant", {30'd0, grant_id}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
